// File: rtl/key_conditioner_if.sv
// Push-button conditioner signal bundle: raw key input and the conditioned event/level outputs.
// The master side is the conditioner; the slave side is whatever consumes the key events.
interface key_conditioner_if;
  logic key_n;
  logic key_pulse;
  logic key_state;
  logic key_level;
  logic long_pulse;
  logic repeat_pulse;
  logic release_pulse;

  modport master (
    input  key_n,
    output key_pulse,
    output key_state,
    output key_level,
    output long_pulse,
    output repeat_pulse,
    output release_pulse
  );

  modport slave (
    output key_n,
    input  key_pulse,
    input  key_state,
    input  key_level,
    input  long_pulse,
    input  repeat_pulse,
    input  release_pulse
  );
endinterface

// File: rtl/key_conditioner.sv
// Push-button conditioner: synchronises a bouncing active-low key, debounces press and release,
// and emits press/release pulses, a run/pause toggle, a debounced level and a long-press pulse.
// Define KEY_REPEAT_EN to add auto-repeat pulses while the key stays held after a long press;
// without it repeat_pulse is tied low and no repeat logic exists.
module key_conditioner #(
  parameter logic [23:0] DEBOUNCE_CYCLES = 24'd240_000,
  parameter logic [23:0] LONG_CYCLES     = 24'd12_000_000,
  parameter logic [23:0] REPEAT_CYCLES   = 24'd2_400_000
) (
  input logic                clk_in,
  input logic                rst_in,
  key_conditioner_if.master  key_if
);

  typedef enum logic [2:0] {
    StIdle,
    StPressDb,
    StHeld,
    StLong,
    StReleaseDb
  } state_e;

  state_e      state_q;
  logic [23:0] dcnt_q;
  logic [23:0] hcnt_q;
  logic        sync1_q;
  logic        key_s_q;
  logic        from_long_q;  // which held state RELEASE_DB returns to on a bounce
  logic        key_pulse_q;
  logic        key_state_q;
  logic        key_level_q;
  logic        long_pulse_q;
  logic        release_pulse_q;

`ifdef KEY_REPEAT_EN
  logic        repeat_pulse_q;
  assign key_if.repeat_pulse = repeat_pulse_q;
`else
  logic        unused_repeat_cycles;
  assign unused_repeat_cycles = ^REPEAT_CYCLES;
  assign key_if.repeat_pulse  = 1'b0;
`endif

  assign key_if.key_pulse     = key_pulse_q;
  assign key_if.key_state     = key_state_q;
  assign key_if.key_level     = key_level_q;
  assign key_if.long_pulse    = long_pulse_q;
  assign key_if.release_pulse = release_pulse_q;

  // Two-flop synchroniser for the asynchronous key; idles high (released).
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sync1_q <= 1'b1;
      key_s_q <= 1'b1;
    end else begin
      sync1_q <= key_if.key_n;
      key_s_q <= sync1_q;
    end
  end

  // Debounce / hold FSM with registered level and single-cycle event outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q         <= StIdle;
      dcnt_q          <= '0;
      hcnt_q          <= '0;
      from_long_q     <= 1'b0;
      key_pulse_q     <= 1'b0;
      key_state_q     <= 1'b0;
      key_level_q     <= 1'b0;
      long_pulse_q    <= 1'b0;
      release_pulse_q <= 1'b0;
`ifdef KEY_REPEAT_EN
      repeat_pulse_q  <= 1'b0;
`endif
    end else begin
      key_pulse_q     <= 1'b0;
      long_pulse_q    <= 1'b0;
      release_pulse_q <= 1'b0;
`ifdef KEY_REPEAT_EN
      repeat_pulse_q  <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (!key_s_q) begin
            state_q <= StPressDb;
            dcnt_q  <= '0;
          end
        end
        StPressDb: begin
          if (key_s_q) begin
            state_q <= StIdle;
            dcnt_q  <= '0;
          end else if (dcnt_q == DEBOUNCE_CYCLES - 24'd1) begin
            state_q     <= StHeld;
            hcnt_q      <= '0;
            from_long_q <= 1'b0;
            key_pulse_q <= 1'b1;
            key_level_q <= 1'b1;
            key_state_q <= ~key_state_q;
          end else begin
            dcnt_q <= dcnt_q + 24'd1;
          end
        end
        StHeld: begin
          // A release edge wins over the long-press compare; hcnt stays frozen meanwhile.
          if (key_s_q) begin
            state_q     <= StReleaseDb;
            dcnt_q      <= '0;
            from_long_q <= 1'b0;
          end else if (hcnt_q == LONG_CYCLES - 24'd1) begin
            state_q      <= StLong;
            long_pulse_q <= 1'b1;
            hcnt_q       <= '0;
          end else begin
            hcnt_q <= hcnt_q + 24'd1;
          end
        end
        StLong: begin
          if (key_s_q) begin
            state_q     <= StReleaseDb;
            dcnt_q      <= '0;
            from_long_q <= 1'b1;
`ifdef KEY_REPEAT_EN
          end else if (hcnt_q == REPEAT_CYCLES - 24'd1) begin
            repeat_pulse_q <= 1'b1;
            hcnt_q         <= '0;
          end else begin
            hcnt_q <= hcnt_q + 24'd1;
          end
`else
          end else begin
            hcnt_q <= '0;
          end
`endif
        end
        StReleaseDb: begin
          if (!key_s_q) begin
            state_q <= from_long_q ? StLong : StHeld;
          end else if (dcnt_q == DEBOUNCE_CYCLES - 24'd1) begin
            state_q         <= StIdle;
            dcnt_q          <= '0;
            key_level_q     <= 1'b0;
            release_pulse_q <= 1'b1;
          end else begin
            dcnt_q <= dcnt_q + 24'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner with short timing parameters. Outputs are compared every cycle
// against an event-level reference model, plus directed timing expectations per scenario.
module tb_key_conditioner;

  localparam int DB  = 4;
  localparam int LNG = 20;
  localparam int REP = 5;
`ifdef KEY_REPEAT_EN
  localparam bit RepOn = 1'b1;
`else
  localparam bit RepOn = 1'b0;
`endif

  logic clk_in;
  logic rst_in;
  key_conditioner_if key_if ();

  key_conditioner #(
    .DEBOUNCE_CYCLES(24'(DB)),
    .LONG_CYCLES    (24'(LNG)),
    .REPEAT_CYCLES  (24'(REP))
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .key_if(key_if)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;

  // Reference model: key_s is key_n delayed by two samples; a level change is accepted once
  // key_s has shown the new value on DB+1 consecutive samples. Hold time counts samples that
  // are pressed and follow a pressed sample; LNG of them give a long press, then every REP
  // more give a repeat.
  bit m_s1, m_s2, m_prev, m_level, m_tog, m_long_phase;
  int m_run, m_ticks;
  bit m_kp, m_lp, m_rep, m_rel;

  task automatic model_step(input logic kn, input logic rst);
    bit ks;
    if (rst) begin
      m_s1 = 1; m_s2 = 1; m_prev = 1; m_run = 0;
      m_level = 0; m_tog = 0; m_long_phase = 0; m_ticks = 0;
      m_kp = 0; m_lp = 0; m_rep = 0; m_rel = 0;
    end else begin
      ks = m_s2;
      m_s2 = m_s1;
      m_s1 = kn;
      m_kp = 0; m_lp = 0; m_rep = 0; m_rel = 0;
      m_run = (ks == m_prev) ? m_run + 1 : 1;
      if (!m_level) begin
        if (!ks && m_run == DB + 1) begin
          m_level = 1; m_tog = !m_tog; m_kp = 1; m_long_phase = 0; m_ticks = 0;
        end
      end else if (ks) begin
        if (m_run == DB + 1) begin
          m_level = 0; m_rel = 1;
        end
      end else if (!m_prev) begin
        m_ticks++;
        if (!m_long_phase) begin
          if (m_ticks == LNG) begin
            m_lp = 1; m_long_phase = 1; m_ticks = 0;
          end
        end else if (!RepOn) begin
          m_ticks = 0;
        end else if (m_ticks == REP) begin
          m_rep = 1; m_ticks = 0;
        end
      end
      m_prev = ks;
    end
  endtask

  function automatic logic [5:0] dut_vec();
    return {key_if.key_pulse, key_if.key_state, key_if.key_level,
            key_if.long_pulse, key_if.repeat_pulse, key_if.release_pulse};
  endfunction

  function automatic logic [5:0] exp_vec();
    return {m_kp, m_tog, m_level, m_lp, m_rep, m_rel};
  endfunction

  // Advance to the next edge (which samples the inputs applied so far), update the model,
  // then apply this cycle's inputs. Outputs read afterwards belong to this cycle.
  task automatic step(input logic kn, input logic rst);
    @(posedge clk_in);
    #1;
    model_step(key_if.key_n, rst_in);
    key_if.key_n = kn;
    rst_in = rst;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
  endtask

  task automatic test_reset();
    for (int c = 0; c < 4; c++) begin
      step(1'b0, 1'b1);
      checks++;
      if (dut_vec() !== 6'b0) begin
        errors++;
        $display("FAIL reset_outputs c=%0d got=%b exp=%b", c, dut_vec(), 6'b0);
      end
    end
    step(1'b1, 1'b0);
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL reset_model got=%b exp=%b", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_clean_press();
    logic [3:0] exp_d;
    do_reset();
    for (int c = 1; c <= 40; c++) begin
      step((c >= 10 && c < 25) ? 1'b0 : 1'b1, 1'b0);
      exp_d = {c == 17, c >= 17, c >= 17 && c < 32, c == 32};
      checks++;
      if ({key_if.key_pulse, key_if.key_state, key_if.key_level, key_if.release_pulse}
          !== exp_d) begin
        errors++;
        $display("FAIL clean_press c=%0d got=%b exp=%b", c,
                 {key_if.key_pulse, key_if.key_state, key_if.key_level,
                  key_if.release_pulse}, exp_d);
      end
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL clean_model c=%0d got=%b exp=%b", c, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_bounce();
    logic kn;
    int   npulse;
    do_reset();
    npulse = 0;
    for (int c = 1; c <= 40; c++) begin
      kn = (c == 10 || c == 11) ? 1'b0 : (c == 12) ? 1'b1 : (c >= 13 && c < 30) ? 1'b0 : 1'b1;
      step(kn, 1'b0);
      npulse += int'(key_if.key_pulse);
      checks++;
      if ({key_if.key_pulse, key_if.release_pulse} !== {c == 20, c == 37}) begin
        errors++;
        $display("FAIL bounce_timing c=%0d got=%b exp=%b", c,
                 {key_if.key_pulse, key_if.release_pulse}, {c == 20, c == 37});
      end
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL bounce_model c=%0d got=%b exp=%b", c, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (npulse !== 1) begin
      errors++;
      $display("FAIL bounce_count got=%0d exp=1", npulse);
    end
    // A two-cycle glitch on its own must not be accepted.
    do_reset();
    for (int c = 1; c <= 30; c++) begin
      step((c == 10 || c == 11) ? 1'b0 : 1'b1, 1'b0);
      checks++;
      if ({key_if.key_pulse, key_if.key_level} !== 2'b00) begin
        errors++;
        $display("FAIL glitch_only c=%0d got=%b exp=00", c,
                 {key_if.key_pulse, key_if.key_level});
      end
    end
  endtask

  task automatic test_long_repeat();
    logic [3:0] exp_d;
    do_reset();
    for (int c = 1; c <= 65; c++) begin
      step((c >= 10 && c < 50) ? 1'b0 : 1'b1, 1'b0);
      exp_d = {c == 17, c == 37, RepOn && (c == 42 || c == 47 || c == 52), c == 57};
      checks++;
      if ({key_if.key_pulse, key_if.long_pulse, key_if.repeat_pulse, key_if.release_pulse}
          !== exp_d) begin
        errors++;
        $display("FAIL long_repeat c=%0d got=%b exp=%b", c,
                 {key_if.key_pulse, key_if.long_pulse, key_if.repeat_pulse,
                  key_if.release_pulse}, exp_d);
      end
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL long_model c=%0d got=%b exp=%b", c, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_release_bounce();
    logic kn;
    int   nkp;
    int   nrel;
    do_reset();
    nkp = 0;
    nrel = 0;
    for (int c = 1; c <= 50; c++) begin
      kn = (c >= 10 && c < 30) ? 1'b0 : (c == 32 || c == 33) ? 1'b0 : 1'b1;
      step(kn, 1'b0);
      if (c > 17) nkp += int'(key_if.key_pulse);
      nrel += int'(key_if.release_pulse);
      checks++;
      if ({key_if.key_level, key_if.release_pulse} !== {c >= 17 && c < 41, c == 41}) begin
        errors++;
        $display("FAIL release_bounce c=%0d got=%b exp=%b", c,
                 {key_if.key_level, key_if.release_pulse}, {c >= 17 && c < 41, c == 41});
      end
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL release_model c=%0d got=%b exp=%b", c, dut_vec(), exp_vec());
      end
    end
    checks++;
    if ({nkp, nrel} !== {32'sd0, 32'sd1}) begin
      errors++;
      $display("FAIL release_counts got kp=%0d rel=%0d exp kp=0 rel=1", nkp, nrel);
    end
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    for (int c = 1; c <= 45; c++) begin
      step((c >= 10) ? 1'b0 : 1'b1, (c == 25) ? 1'b1 : 1'b0);
      if (c == 26) begin
        checks++;
        if (dut_vec() !== 6'b0) begin
          errors++;
          $display("FAIL reset_hold_clear got=%b exp=%b", dut_vec(), 6'b0);
        end
      end
      if (c >= 26) begin
        checks++;
        if ({key_if.key_pulse, key_if.key_state} !== {c == 33, c >= 33}) begin
          errors++;
          $display("FAIL reset_hold_repress c=%0d got=%b exp=%b", c,
                   {key_if.key_pulse, key_if.key_state}, {c == 33, c >= 33});
        end
      end
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL reset_hold_model c=%0d got=%b exp=%b", c, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_toggle();
    int nkp;
    int nrel;
    int k;
    do_reset();
    nkp = 0;
    nrel = 0;
    for (int c = 1; c <= 100; c++) begin
      // Presses occupy cycles 10..24, 40..54 and 70..84.
      step(((c - 10) % 30 < 15 && c >= 10) ? 1'b0 : 1'b1, 1'b0);
      nkp += int'(key_if.key_pulse);
      nrel += int'(key_if.release_pulse);
      if (c >= 18 && (c - 18) % 30 == 0) begin
        k = (c - 18) / 30;
        checks++;
        if (key_if.key_state !== ((k % 2) == 0)) begin
          errors++;
          $display("FAIL toggle_state press=%0d got=%b exp=%b", k, key_if.key_state,
                   (k % 2) == 0);
        end
      end
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL toggle_model c=%0d got=%b exp=%b", c, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (nkp !== 3 || nrel !== 3) begin
      errors++;
      $display("FAIL toggle_counts got kp=%0d rel=%0d exp kp=3 rel=3", nkp, nrel);
    end
  endtask

  task automatic test_random();
    int  c;
    int  len;
    bit  v;
    bit  r;
    do_reset();
    c = 0;
    while (c < 4000) begin
      v = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 5) == 0) ? int'($urandom_range(20, 70))
                                        : int'($urandom_range(1, 8));
      for (int i = 0; i < len && c < 4000; i++) begin
        r = ($urandom_range(0, 499) == 0);
        step(v, r);
        c++;
        checks++;
        if (dut_vec() !== exp_vec()) begin
          errors++;
          $display("FAIL random_model c=%0d got=%b exp=%b", c, dut_vec(), exp_vec());
        end
        checks++;
        if (key_if.key_pulse && key_if.long_pulse) begin
          errors++;
          $display("FAIL random_kp_lp_overlap c=%0d got=11 exp=not both", c);
        end
      end
    end
  endtask

  initial begin
    key_if.key_n = 1'b1;
    rst_in = 1'b1;
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_repeat();
    test_release_bounce();
    test_reset_mid_hold();
    test_toggle();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 SHALL provide parameter DEBOUNCE_CYCLES, default 24'd240_000, consecutive stable cycles needed to accept a level change (20 ms at 12 MHz).
REQ-002 SHALL provide parameter LONG_CYCLES, default 24'd12_000_000, cycles from accepted press to long-press event (1 s at 12 MHz).
REQ-003 SHALL provide parameter REPEAT_CYCLES, default 24'd2_400_000, auto-repeat period after long press (200 ms at 12 MHz).
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk_in  input  1  system clock, 12 MHz.
REQ-006 rst_in  input  1  synchronous active-high reset.
REQ-007 key_n  input  1  raw push-button, active low, asynchronous to clk_in, bouncing.
REQ-008 key_pulse  output  1  one-cycle pulse on each accepted press.
REQ-009 key_state  output  1  toggle level, inverts on each accepted press (run/pause control for the 60 s timer).
REQ-010 key_level  output  1  debounced level, 1 = pressed.
REQ-011 long_pulse  output  1  one-cycle pulse when press held LONG_CYCLES.
REQ-012 repeat_pulse  output  1  one-cycle auto-repeat pulse (see Configuration).
REQ-013 release_pulse  output  1  one-cycle pulse on each accepted release.

Function
REQ-014 key_n SHALL pass a 2-flop synchronizer (reset value 1); all logic uses the second-stage value key_s (press = key_s 0).
REQ-015 FSM states SHALL be IDLE, PRESS_DB, HELD, LONG, RELEASE_DB; one 24-bit debounce counter dcnt, one 24-bit hold counter hcnt.
REQ-016 IDLE: key_s 0 -> PRESS_DB, dcnt=0; else stay.
REQ-017 PRESS_DB: key_s 1 -> IDLE, dcnt=0; key_s 0 and dcnt==DEBOUNCE_CYCLES-1 -> HELD, hcnt=0, and in that same transition cycle key_pulse=1 next cycle, key_level=1, key_state toggles; else dcnt+1.
REQ-018 Press latency: key_pulse SHALL assert exactly DEBOUNCE_CYCLES+3 cycles after the first clk_in edge sampling key_n low (2 sync + DEBOUNCE_CYCLES count + 1 register), given no bounce.
REQ-019 HELD: hcnt+1 each cycle; hcnt==LONG_CYCLES-1 -> LONG, long_pulse=1 for one cycle, hcnt=0; key_s 1 -> RELEASE_DB, dcnt=0, hcnt frozen.
REQ-020 LONG: hcnt counts per REQ-030/031; key_s 1 -> RELEASE_DB, dcnt=0.
REQ-021 RELEASE_DB: key_s 0 -> return to originating state (HELD or LONG, held in 1-bit flag), hcnt resumes from frozen value; key_s 1 and dcnt==DEBOUNCE_CYCLES-1 -> IDLE, key_level=0, release_pulse=1 one cycle; else dcnt+1.
REQ-022 key_level SHALL stay 1 throughout HELD, LONG and RELEASE_DB.
REQ-023 All pulse outputs SHALL be registered, one cycle wide, never asserted in consecutive cycles by the same event.
REQ-024 key_pulse and long_pulse SHALL never assert in the same cycle; when LONG_CYCLES-1==0 long_pulse fires one cycle after key_pulse.
REQ-025 Counters SHALL saturate-safe compare with ==; parameters SHALL be 1..2^24-1; values of 0 are illegal and not supported.

Reset
REQ-026 rst_in=1 at clk_in edge SHALL force: state IDLE, dcnt=0, hcnt=0, sync flops=1, key_state=0, key_level=0, all pulses 0.
REQ-027 Reset mid-press SHALL discard the press; after release of rst_in with key_n still low, a fresh full debounce SHALL occur before key_pulse.
REQ-028 No output SHALL depend on rst_in combinationally.

Configuration
REQ-029 Macro KEY_REPEAT_EN SHALL select auto-repeat.
REQ-030 With KEY_REPEAT_EN defined: in LONG, hcnt==REPEAT_CYCLES-1 -> repeat_pulse=1 one cycle, hcnt=0; repeats while in LONG; frozen in RELEASE_DB.
REQ-031 Without KEY_REPEAT_EN: repeat_pulse SHALL be tied 0, LONG holds hcnt at 0, no repeat logic synthesized.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=5)
REQ-032 Clean press: key_n low at cycle 10 held -> key_pulse cycle 17 only, key_state 0->1, key_level 1 from cycle 17.
REQ-033 Bounce: key_n low 2 cycles, high 1, low steady -> exactly one key_pulse, 4 stable cycles after last bounce edge + sync; no pulse for the 2-cycle glitch alone.
REQ-034 Long + repeat (KEY_REPEAT_EN): hold 40 cycles -> long_pulse 20 cycles after key_pulse, repeat_pulse every 5 cycles thereafter; without macro repeat_pulse stays 0.
REQ-035 Release bounce: release with 2-cycle low glitch inside RELEASE_DB -> no second key_pulse, single release_pulse after 4 stable high cycles.
REQ-036 Reset mid-hold: assert rst_in in HELD for 1 cycle with key_n low -> all outputs 0 next cycle, key_state 0, new key_pulse 7 cycles after rst_in deasserts.
REQ-037 Toggle: three clean presses -> key_state 1, 0, 1; three key_pulse, three release_pulse.
